// File: rtl/ysyx_22051013_pip_ctrl_pkg.sv
// Shared definitions for the pipeline controller: FSM encodings, shadow slot layout, reset level.
package ysyx_22051013_pip_ctrl_pkg;

   localparam logic RST_ACTIVE = 1'b0;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MDU_WAIT = 2'd1,
      ST_MEM_WAIT = 2'd2,
      ST_DRAIN    = 2'd3
   } state_e;

   localparam int NSLOT    = 3;
   localparam int SLOT_EX  = 0;
   localparam int SLOT_MEM = 1;
   localparam int SLOT_WB  = 2;

   typedef struct packed {
      logic valid;
      logic wen;
      logic load;
      logic mdu;
   } slot_flags_t;

   // Drain counter saturates one past the limit, so it needs room for DRAIN_MAX+1.
   function automatic int drain_cnt_width(input int drain_max);
      return $clog2(drain_max + 2);
   endfunction

endpackage

// File: rtl/ysyx_22051013_pip_ctrl_hzd.sv
// RAW / load-use comparator between the ID sources and the EX/MEM/WB shadows.
// YSYX_22051013_FORWARD_EN: only EX-slot loads and MDU ops interlock; otherwise EX and MEM both do.
module ysyx_22051013_pip_hzd
   import ysyx_22051013_pip_ctrl_pkg::*;
#(
   parameter int REG_AW = 5
) (
   input  logic                          id_valid,
   input  logic                          id_rs1_ena,
   input  logic                          id_rs2_ena,
   input  logic [REG_AW-1:0]             id_rs1,
   input  logic [REG_AW-1:0]             id_rs2,
   input  slot_flags_t [NSLOT-1:0]       slot_flags,
   input  logic [NSLOT-1:0][REG_AW-1:0]  slot_rd,
   output logic                          raw_stall
);

`ifdef YSYX_22051013_FORWARD_EN
   localparam logic [NSLOT-1:0] STALL_SLOTS = 3'b001;
   localparam logic             KIND_ONLY   = 1'b1;
`else
   localparam logic [NSLOT-1:0] STALL_SLOTS = 3'b011;
   localparam logic             KIND_ONLY   = 1'b0;
`endif

   logic [NSLOT-1:0] hit1;
   logic [NSLOT-1:0] hit2;
   logic             rs1_live;
   logic             rs2_live;

   // WB is write-through to the regfile, so its STALL_SLOTS bit is always clear.
   genvar gi;
   for (gi = 0; gi < NSLOT; gi++) begin : g_slot
      logic producer;
      assign producer = STALL_SLOTS[gi] & slot_flags[gi].valid & slot_flags[gi].wen &
                        (KIND_ONLY ? (slot_flags[gi].load | slot_flags[gi].mdu) : 1'b1);
      assign hit1[gi] = producer & (slot_rd[gi] == id_rs1);
      assign hit2[gi] = producer & (slot_rd[gi] == id_rs2);
   end

   assign rs1_live  = id_rs1_ena & (id_rs1 != '0);
   assign rs2_live  = id_rs2_ena & (id_rs2 != '0);
   assign raw_stall = id_valid & ((rs1_live & |hit1) | (rs2_live & |hit2));

endmodule

// File: rtl/ysyx_22051013_pip_ctrl.sv
// Central stall/flush scheduler for the 5-stage pipeline; tracks EX/MEM/WB occupancy in shadow slots.
// Macro YSYX_22051013_FORWARD_EN (used in the hazard comparator) relaxes the RAW interlock.
module ysyx_22051013_pip_ctrl
   import ysyx_22051013_pip_ctrl_pkg::*;
#(
   parameter int REG_AW    = 5,
   parameter int DRAIN_MAX = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic              id_rs1_ena,
   input  logic              id_rs2_ena,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_wen,
   input  logic              id_load,
   input  logic              id_mdu,
   input  logic              id_serial,
   input  logic              ex_redirect,
   input  logic              mdu_done,
   input  logic              mem_req,
   input  logic              mem_ready,
   output logic              stall_pc,
   output logic              stall_ifid,
   output logic              stall_idex,
   output logic              stall_exmem,
   output logic              bubble_ex,
   output logic              bubble_mem,
   output logic              bubble_wb,
   output logic              flush_ifid,
   output logic              drain_err,
   output logic [1:0]        state_o
);

   localparam int               CNT_W   = drain_cnt_width(DRAIN_MAX);
   localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(DRAIN_MAX);
   localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(DRAIN_MAX + 1);

   state_e                       state_q, state_d;
   slot_flags_t [NSLOT-1:0]      flags_q, flags_d;
   logic [NSLOT-1:0][REG_AW-1:0] rd_q, rd_d;
   logic [CNT_W-1:0]             cnt_q, cnt_d;
   logic                         err_q, err_d;

   logic mem_wait;
   logic mdu_wait;
   logic serial_busy;
   logic raw_stall;
   logic issue;

   assign mem_wait    = flags_q[SLOT_MEM].valid & mem_req & ~mem_ready;
   assign mdu_wait    = flags_q[SLOT_EX].valid & flags_q[SLOT_EX].mdu & ~mdu_done;
   assign serial_busy = id_valid & id_serial & (flags_q[SLOT_EX].valid | flags_q[SLOT_MEM].valid);

   ysyx_22051013_pip_hzd #(
      .REG_AW (REG_AW)
   ) u_hzd (
      .id_valid   (id_valid),
      .id_rs1_ena (id_rs1_ena),
      .id_rs2_ena (id_rs2_ena),
      .id_rs1     (id_rs1),
      .id_rs2     (id_rs2),
      .slot_flags (flags_q),
      .slot_rd    (rd_q),
      .raw_stall  (raw_stall)
   );

   // Priority: MEM_WAIT > MDU_WAIT > redirect > DRAIN > RAW.
   always_comb begin : arbiter
      stall_pc    = 1'b0;
      stall_ifid  = 1'b0;
      stall_idex  = 1'b0;
      stall_exmem = 1'b0;
      bubble_ex   = 1'b0;
      bubble_mem  = 1'b0;
      bubble_wb   = 1'b0;
      flush_ifid  = 1'b0;
      state_d     = ST_RUN;
      if (rst == RST_ACTIVE) begin
         bubble_ex  = 1'b1;
         bubble_mem = 1'b1;
         bubble_wb  = 1'b1;
         flush_ifid = 1'b1;
      end else if (mem_wait) begin
         stall_pc    = 1'b1;
         stall_ifid  = 1'b1;
         stall_idex  = 1'b1;
         stall_exmem = 1'b1;
         bubble_wb   = 1'b1;
         state_d     = ST_MEM_WAIT;
      end else if (mdu_wait) begin
         stall_pc   = 1'b1;
         stall_ifid = 1'b1;
         stall_idex = 1'b1;
         bubble_mem = 1'b1;
         state_d    = ST_MDU_WAIT;
      end else if (ex_redirect) begin
         flush_ifid = 1'b1;
         bubble_ex  = 1'b1;
      end else if (serial_busy) begin
         stall_pc   = 1'b1;
         stall_ifid = 1'b1;
         bubble_ex  = 1'b1;
         state_d    = ST_DRAIN;
      end else if (raw_stall) begin
         stall_pc   = 1'b1;
         stall_ifid = 1'b1;
         bubble_ex  = 1'b1;
      end
   end

   assign issue = id_valid & ~stall_idex & ~bubble_ex;

   always_comb begin : shadow_next
      flags_d = flags_q;
      rd_d    = rd_q;
      if (bubble_wb) begin
         flags_d[SLOT_WB] = '0;
      end else begin
         flags_d[SLOT_WB] = flags_q[SLOT_MEM];
         rd_d[SLOT_WB]    = rd_q[SLOT_MEM];
      end
      if (!stall_exmem) begin
         if (bubble_mem) begin
            flags_d[SLOT_MEM] = '0;
         end else begin
            flags_d[SLOT_MEM] = flags_q[SLOT_EX];
            rd_d[SLOT_MEM]    = rd_q[SLOT_EX];
         end
      end
      if (!stall_idex) begin
         flags_d[SLOT_EX] = '0;
         if (issue) begin
            flags_d[SLOT_EX].valid = 1'b1;
            flags_d[SLOT_EX].wen   = id_wen & (id_rd != '0);
            flags_d[SLOT_EX].load  = id_load;
            flags_d[SLOT_EX].mdu   = id_mdu;
            rd_d[SLOT_EX]          = id_rd;
         end
      end
   end

   // Watchdog follows the drain condition itself, even while a wait outranks it.
   always_comb begin : drain_watch
      cnt_d = '0;
      err_d = err_q;
      if (serial_busy) begin
         cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
         if (cnt_d > CNT_LIM) begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst == RST_ACTIVE) begin
         state_q <= ST_RUN;
         flags_q <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         flags_q <= flags_d;
         rd_q    <= rd_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign drain_err = err_q;
   assign state_o   = state_q;

endmodule

// File: tb/tb_ysyx_22051013_pip_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic against an in-flight instruction model.
module tb_ysyx_22051013_pip_ctrl;

`ifdef YSYX_22051013_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif
   localparam int MAX_A = 15;
   localparam int MAX_B = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, id_valid, id_rs1_ena, id_rs2_ena;
   logic [4:0] id_rs1, id_rs2, id_rd;
   logic       id_wen, id_load, id_mdu, id_serial, ex_redirect, mdu_done, mem_req, mem_ready;

   logic spc_a, sif_a, sie_a, sem_a, bex_a, bme_a, bwb_a, fl_a, err_a;
   logic spc_b, sif_b, sie_b, sem_b, bex_b, bme_b, bwb_b, fl_b, err_b;
   logic [1:0] st_a, st_b;

   ysyx_22051013_pip_ctrl #(.REG_AW(5), .DRAIN_MAX(MAX_A)) u_dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1_ena(id_rs1_ena), .id_rs2_ena(id_rs2_ena),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_wen(id_wen), .id_load(id_load),
      .id_mdu(id_mdu), .id_serial(id_serial), .ex_redirect(ex_redirect), .mdu_done(mdu_done),
      .mem_req(mem_req), .mem_ready(mem_ready), .stall_pc(spc_a), .stall_ifid(sif_a),
      .stall_idex(sie_a), .stall_exmem(sem_a), .bubble_ex(bex_a), .bubble_mem(bme_a),
      .bubble_wb(bwb_a), .flush_ifid(fl_a), .drain_err(err_a), .state_o(st_a));

   ysyx_22051013_pip_ctrl #(.REG_AW(5), .DRAIN_MAX(MAX_B)) u_dut_d1 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1_ena(id_rs1_ena), .id_rs2_ena(id_rs2_ena),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_wen(id_wen), .id_load(id_load),
      .id_mdu(id_mdu), .id_serial(id_serial), .ex_redirect(ex_redirect), .mdu_done(mdu_done),
      .mem_req(mem_req), .mem_ready(mem_ready), .stall_pc(spc_b), .stall_ifid(sif_b),
      .stall_idex(sie_b), .stall_exmem(sem_b), .bubble_ex(bex_b), .bubble_mem(bme_b),
      .bubble_wb(bwb_b), .flush_ifid(fl_b), .drain_err(err_b), .state_o(st_b));

   typedef struct {
      bit rst_n; bit vld; bit e1; bit e2; int rs1; int rs2; int rd;
      bit wen; bit ld; bit md; bit ser; bit redir; bit done; bit mreq; bit mrdy;
   } stim_t;

   typedef struct { bit v; int rd; bit w; bit ld; bit md; } ins_t;

   ins_t m_ex, m_mem, m_wb;
   int   m_state;
   int   m_cnt [2];
   bit   m_err [2];

   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc   = 0;
   logic [10:0] obs_a, obs_b;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic ins_t empty_ins();
      ins_t e = '{v: 1'b0, rd: 0, w: 1'b0, ld: 1'b0, md: 1'b0};
      return e;
   endfunction

   function automatic stim_t idle();
      stim_t s = '{default: 0};
      s.rst_n = 1'b1;
      return s;
   endfunction

   // A source conflicts with an older in-flight writer it cannot yet read.
   function automatic bit conflict(input int rs);
      if (rs == 0) return 1'b0;
      if (m_ex.v && m_ex.w && m_ex.rd == rs && (!FWD || m_ex.ld || m_ex.md)) return 1'b1;
      if (!FWD && m_mem.v && m_mem.w && m_mem.rd == rs) return 1'b1;
      return 1'b0;
   endfunction

   task automatic drive(input stim_t s);
      rst = s.rst_n; id_valid = s.vld; id_rs1_ena = s.e1; id_rs2_ena = s.e2;
      id_rs1 = 5'(s.rs1); id_rs2 = 5'(s.rs2); id_rd = 5'(s.rd);
      id_wen = s.wen; id_load = s.ld; id_mdu = s.md; id_serial = s.ser;
      ex_redirect = s.redir; mdu_done = s.done; mem_req = s.mreq; mem_ready = s.mrdy;
   endtask

   task automatic step(input stim_t s);
      bit mw, dw, dr, rw, iss;
      int win;
      bit [7:0] ctl;   // stall_pc stall_ifid stall_idex stall_exmem bubble_ex bubble_mem bubble_wb flush
      logic [1:0] st_exp;
      @(negedge clk);
      drive(s);
      #2;
      cyc++;
      mw = m_mem.v && s.mreq && !s.mrdy;
      dw = m_ex.v && m_ex.md && !s.done;
      dr = s.vld && s.ser && (m_ex.v || m_mem.v);
      rw = s.vld && ((s.e1 && conflict(s.rs1)) || (s.e2 && conflict(s.rs2)));
      win = 0;
      ctl = 8'b0000_0000;
      if (!s.rst_n)    ctl = 8'b0000_1111;
      else if (mw)     begin ctl = 8'b1111_0010; win = 2; end
      else if (dw)     begin ctl = 8'b1110_0100; win = 1; end
      else if (s.redir) ctl = 8'b0000_1001;
      else if (dr)     begin ctl = 8'b1100_1000; win = 3; end
      else if (rw)     ctl = 8'b1100_1000;

      st_exp = m_state[1:0];
      obs_a = {spc_a, sif_a, sie_a, sem_a, bex_a, bme_a, bwb_a, fl_a, err_a, st_a};
      obs_b = {spc_b, sif_b, sie_b, sem_b, bex_b, bme_b, bwb_b, fl_b, err_b, st_b};
      chk($sformatf("c%0d_ctrl_a", cyc), 32'(obs_a), 32'({ctl, m_err[0], st_exp}));
      chk($sformatf("c%0d_ctrl_b", cyc), 32'(obs_b), 32'({ctl, m_err[1], st_exp}));

      if (!s.rst_n) begin
         m_ex = empty_ins(); m_mem = empty_ins(); m_wb = empty_ins();
         m_state = 0; m_cnt = '{0, 0}; m_err = '{1'b0, 1'b0};
      end else begin
         iss = s.vld && !ctl[5] && !ctl[3];
         if (mw) begin
            m_wb = empty_ins();
         end else begin
            m_wb = m_mem;
            if (dw) m_mem = empty_ins();
            else begin
               m_mem = m_ex;
               if (iss) m_ex = '{v: 1'b1, rd: s.rd, w: s.wen && s.rd != 0, ld: s.ld, md: s.md};
               else     m_ex = empty_ins();
            end
         end
         m_state = win;
         for (int k = 0; k < 2; k++) begin
            if (dr) begin
               m_cnt[k]++;
               if (m_cnt[k] > ((k == 0) ? MAX_A : MAX_B)) m_err[k] = 1'b1;
            end else begin
               m_cnt[k] = 0;
            end
         end
      end
   endtask

   // Keep one instruction in ID until the controller stops holding the PC; count held cycles.
   task automatic hold_until_issue(input stim_t s, input string tag, input int want);
      int n = 0;
      bit gone = 1'b0;
      for (int k = 0; k < 20 && !gone; k++) begin
         step(s);
         if (obs_a[10]) n++;
         else gone = 1'b1;
      end
      if (!gone) chk({tag, "_timeout"}, 32'(obs_a[10]), 32'd0);
      chk(tag, 32'(n), 32'(want));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      stim_t s;
      m_ex = empty_ins(); m_mem = empty_ins(); m_wb = empty_ins();
      m_state = 0; m_cnt = '{0, 0}; m_err = '{1'b0, 1'b0};

      s = idle(); s.rst_n = 1'b0; s.vld = 1'b1;
      drive(s);
      step(s);
      step(s);
      chk("rst_stalls", 32'(obs_a[10:7]), 32'd0);
      chk("rst_flush_bex", 32'({obs_a[6], obs_a[3]}), 32'b11);

      // Load-use: lw x5, then add x6,x5,x1
      s = idle(); s.vld = 1; s.rd = 5; s.wen = 1; s.ld = 1;
      step(s);
      s = idle(); s.vld = 1; s.rd = 6; s.wen = 1; s.e1 = 1; s.rs1 = 5; s.e2 = 1; s.rs2 = 1;
      hold_until_issue(s, "loaduse_stall", FWD ? 1 : 2);
      for (int k = 0; k < 3; k++) step(idle());

      // MDU: mul x7 waits four cycles for its result
      s = idle(); s.vld = 1; s.rd = 7; s.wen = 1; s.md = 1;
      step(s);
      s = idle(); s.vld = 1; s.rd = 8; s.wen = 1; s.e1 = 1; s.rs1 = 1;
      for (int k = 0; k < 4; k++) begin
         step(s);
         chk($sformatf("mdu_hold%0d", k), 32'({obs_a[8], obs_a[5]}), 32'b11);
      end
      s.done = 1;
      step(s);
      chk("mdu_release", 32'(obs_a[10:7]), 32'd0);
      for (int k = 0; k < 3; k++) step(idle());

      // LSU wait with a stray redirect
      s = idle(); s.vld = 1; s.rd = 9; s.wen = 1; s.ld = 1;
      step(s);
      step(idle());
      s = idle(); s.mreq = 1; s.redir = 1;
      for (int k = 0; k < 3; k++) begin
         step(s);
         chk($sformatf("lsu_hold%0d", k), 32'({obs_a[10:7], obs_a[3]}), 32'b11110);
      end
      s = idle(); s.mreq = 1; s.mrdy = 1;
      step(s);
      for (int k = 0; k < 3; k++) step(idle());

      // Serialize: csrrw behind two ALU ops
      s = idle(); s.vld = 1; s.rd = 10; s.wen = 1;
      step(s);
      s.rd = 11;
      step(s);
      s = idle(); s.vld = 1; s.rd = 12; s.wen = 1; s.ser = 1;
      hold_until_issue(s, "drain_cycles", 2);
      step(idle());
      chk("drain_err_max15", 32'(obs_a[2]), 32'd0);
      chk("drain_err_max1", 32'(obs_b[2]), 32'd1);
      for (int k = 0; k < 2; k++) step(idle());

      // x0 destination never creates a hazard
      s = idle(); s.vld = 1; s.rd = 0; s.wen = 1;
      step(s);
      s = idle(); s.vld = 1; s.rd = 13; s.wen = 1; s.e1 = 1; s.rs1 = 0; s.e2 = 1; s.rs2 = 0;
      hold_until_issue(s, "x0_stall", 0);

      // Random traffic
      for (int k = 0; k < 800; k++) begin
         s = idle();
         s.rst_n = ($urandom_range(0, 199) != 0);
         s.vld   = ($urandom_range(0, 3) != 0);
         if (s.vld) begin
            s.e1  = $urandom_range(0, 1) != 0;
            s.e2  = $urandom_range(0, 1) != 0;
            s.rs1 = int'($urandom_range(0, 7));
            s.rs2 = int'($urandom_range(0, 7));
            s.rd  = int'($urandom_range(0, 7));
            s.wen = $urandom_range(0, 1) != 0;
            s.ld  = $urandom_range(0, 3) == 0;
            s.md  = $urandom_range(0, 5) == 0;
            s.ser = $urandom_range(0, 11) == 0;
         end
         s.redir = $urandom_range(0, 9) == 0;
         s.done  = $urandom_range(0, 2) == 0;
         s.mreq  = $urandom_range(0, 1) != 0;
         s.mrdy  = $urandom_range(0, 1) != 0;
         step(s);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ysyx_22051013_pip_ctrl.md
Name: ysyx_22051013_pip_ctrl

Overview:
- Central stall/flush scheduler for the 5-stage pipeline (IF/ID/EX/MEM/WB).
- Keeps a shadow copy of the EX/MEM/WB slots (valid, rd, wen, load, mdu) and uses it to detect RAW, load-use, multi-cycle MDU and LSU-wait hazards.
- Drives per-stage hold and bubble controls plus redirect flush. Inputs come from the decode stage (rs enables, load flag, rd) and from the EX/MEM handshakes.

Parameters:
- REG_AW, 5, register index width.
- DRAIN_MAX, 15, watchdog limit in cycles for serialize drain; overflow raises drain_err.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous reset, active-low (rst==0 resets on clk rising edge)
- id_valid  in  1  ID holds a real instruction
- id_rs1_ena / id_rs2_ena  in  1  source operand used
- id_rs1 / id_rs2  in  REG_AW  source index
- id_rd  in  REG_AW  destination index
- id_wen  in  1  instruction writes rd
- id_load  in  1  load instruction
- id_mdu  in  1  mul/div/rem (multi-cycle)
- id_serial  in  1  csr*/ecall/ebreak/mret; must execute with EX and MEM empty
- ex_redirect  in  1  EX resolved a taken branch or jump this cycle
- mdu_done  in  1  MDU result valid this cycle
- mem_req  in  1  MEM slot holds a load/store
- mem_ready  in  1  LSU completes this cycle
- stall_pc, stall_ifid, stall_idex, stall_exmem  out  1  hold the named register
- bubble_ex, bubble_mem, bubble_wb  out  1  load NOP into the named stage register
- flush_ifid  out  1  kill the instruction in IF/ID
- drain_err  out  1  sticky; drain exceeded DRAIN_MAX
- state_o  out  2  current FSM state (debug)

Behaviour:
- Reset (rst==0): all shadow slots invalid, state=RUN, drain counter 0, drain_err 0. While rst is low: stall_* = 0, flush_ifid = 1, bubble_ex = bubble_mem = bubble_wb = 1.
- Issue: issue = id_valid & ~stall_idex & ~bubble_ex. On issue, the EX shadow loads {1, id_rd, id_wen & (id_rd!=0), id_load, id_mdu}.
- Shadow advance: EX→MEM when ~stall_exmem; MEM→WB when ~bubble_wb. A bubble in a stage writes valid=0 into its shadow slot.
- States: RUN=0, MDU_WAIT=1, MEM_WAIT=2, DRAIN=3. Conditions are evaluated combinationally each cycle in priority order MEM_WAIT > MDU_WAIT > redirect > DRAIN > RAW; state_o registers the winning condition.
- MEM_WAIT (MEM shadow valid & mem_req & ~mem_ready): stall_pc, stall_ifid, stall_idex, stall_exmem = 1; bubble_wb = 1. The cycle mem_ready rises, MEM advances.
- MDU_WAIT (EX shadow mdu & ~mdu_done): stall_pc, stall_ifid, stall_idex = 1; bubble_mem = 1. With mdu_done, EX advances in that same cycle.
- Redirect: ex_redirect is honoured only when EX advances (not in MEM_WAIT/MDU_WAIT). Then flush_ifid = 1, bubble_ex = 1, no stall. A redirect arriving during a wait is a bench error; the block ignores it.
- DRAIN (id_valid & id_serial & any EX/MEM shadow valid): stall_pc, stall_ifid = 1; bubble_ex = 1. The drain counter increments each cycle; if it exceeds DRAIN_MAX, drain_err is set (sticky until reset). The counter clears when the drain ends.
- RAW hazard, no forwarding: stall if rsX_ena & rsX!=0 & rsX==rd of a valid wen slot in EX or MEM. The WB slot never conflicts (regfile is write-through). Response: stall_pc, stall_ifid = 1; bubble_ex = 1.
- x0 is never a hazard. Simultaneous rs1 and rs2 hazards give a single stall.

Optional Feature:
- Macro YSYX_22051013_FORWARD_EN.
- Defined: EX/MEM→ID forwarding exists. RAW stall only for load-use (EX slot load & match) or EX slot mdu & match; MEM-slot matches never stall.
- Undefined: full RAW interlock as specified above. All other behaviour is identical.

Decomposition:
- Shared package/define file holds:
  - state encodings (RUN/MDU_WAIT/MEM_WAIT/DRAIN)
  - shadow slot field widths
  - RSTABLE-style active-low reset constant
- One natural sub-module, ysyx_22051013_pip_hzd: combinational RAW/load-use comparator taking the ID sources and EX/MEM shadows and producing raw_stall. The macro applies inside it.

Test Plan:
- Reset: hold rst=0 for 2 cycles with id_valid=1 → flush_ifid=1, bubble_ex=1, all stall_*=0. First cycle after release: state_o=0.
- Load-use: issue lw x5, then add x6,x5,x1 (rs1=5). With FORWARD_EN: exactly 1 cycle stall_pc/stall_ifid=1 plus bubble_ex. Without it: 2 cycles.
- MDU: issue mul x7 with mdu_done low for 4 cycles → stall_idex=1 and bubble_mem=1 for 4 cycles, state_o=1. Next cycle after mdu_done=1: all stalls 0.
- LSU wait during redirect: mem_req=1, mem_ready=0 for 3 cycles while ex_redirect=1 → stalls asserted, flush_ifid=0. The block ignores the redirect until MEM advances.
- Serialize: csrrw issued behind two ALU ops → DRAIN for 2 cycles, then issue. With DRAIN_MAX=1 and the same stimulus, drain_err=1.
- x0 target: addi x0 followed by a reader of x0 → zero stall cycles.
